mem_fu_nb: RTL

- Non-blocking memory functional unit. Computes effective addresses for loads and stores.
- Forwards each store to the store queue in the same cycle it is issued.
- Holds up to NUM_PENDING missed loads and retries them against the dcache round-robin, so loads can complete out of order.
- Sits between the mem reservation station and the dcache/store queue, and drives one CDB request through a registered result slot with a grant handshake.

---
 rtl/mem_fu_nb_pkg.sv | 72 +++++++
 rtl/mem_fu_nb_pend_buf.sv | 79 +++++++
 rtl/mem_fu_nb.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_fu_nb_pkg.sv
// Shared types and helpers for the non-blocking memory functional unit:
// op encoding, pending-load entry layout, byte-lane mask and load extraction.
package mem_fu_nb_pkg;

  localparam int unsigned MAX_TAG_W = 16;

  typedef enum logic [3:0] {
    MF_LB  = 4'd0,
    MF_LH  = 4'd1,
    MF_LW  = 4'd2,
    MF_LD  = 4'd3,
    MF_LBU = 4'd4,
    MF_LHU = 4'd5,
    MF_SB  = 4'd6,
    MF_SH  = 4'd7,
    MF_SW  = 4'd8,
    MF_SD  = 4'd9
  } mem_func_e;

  // Tag is stored at MAX_TAG_W bits; users keep only their low TAG_W bits.
  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
    logic [31:0]          addr;
    mem_func_e            func;
  } mem_pend_entry_t;

  function automatic logic func_is_store(input mem_func_e f);
    return (f == MF_SB) || (f == MF_SH) || (f == MF_SW) || (f == MF_SD);
  endfunction

  // 0 = byte, 1 = half, 2 = word, 3 = doubleword
  function automatic logic [1:0] func_size(input mem_func_e f);
    logic [1:0] s;
    case (f)
      MF_LB, MF_LBU, MF_SB: s = 2'd0;
      MF_LH, MF_LHU, MF_SH: s = 2'd1;
      MF_LW, MF_SW:         s = 2'd2;
      default:              s = 2'd3;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] byte_mask(input mem_func_e f, input logic [2:0] off);
    logic [7:0] m;
    case (func_size(f))
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

  // LD is doubleword aligned, so it returns the low word of the line.
  function automatic logic [31:0] load_extract(input mem_func_e f, input logic [63:0] dw,
                                               input logic [2:0] off);
    logic [63:0] sh;
    logic [31:0] r;
    sh = dw >> {off, 3'b000};
    case (f)
      MF_LB:                r = {{24{sh[7]}}, sh[7:0]};
      MF_LBU:               r = {24'b0, sh[7:0]};
      MF_LH:                r = {{16{sh[15]}}, sh[15:0]};
      MF_LHU:               r = {16'b0, sh[15:0]};
      MF_LW, MF_LD:         r = sh[31:0];
      default:              r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_fu_nb_pend_buf.sv
// Pending-load buffer: entry array, lowest-free allocation, round-robin
// retry selection starting at the rr pointer, and occupancy count.
module mem_pend_buf
  import mem_fu_nb_pkg::*;
#(
  parameter int unsigned NUM_PENDING = 4,
  parameter int unsigned PEND_IDX_W  = $clog2(NUM_PENDING)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic                  i_alloc,
  input  mem_pend_entry_t       i_alloc_entry,
  input  logic                  i_free,
  input  logic [PEND_IDX_W-1:0] i_free_idx,
  input  logic                  i_advance,
  output logic                  o_sel_valid,
  output logic [PEND_IDX_W-1:0] o_sel_idx,
  output mem_pend_entry_t       o_sel_entry,
  output logic [PEND_IDX_W:0]   o_count
);

  mem_pend_entry_t       r_entries [NUM_PENDING];
  logic [PEND_IDX_W-1:0] r_rr;
  logic [PEND_IDX_W-1:0] w_alloc_idx;
  logic                  w_alloc_found;

  always_comb begin
    w_alloc_idx   = '0;
    w_alloc_found = 1'b0;
    for (int unsigned i = 0; i < NUM_PENDING; i++) begin
      if (!w_alloc_found && !r_entries[i].valid) begin
        w_alloc_idx   = PEND_IDX_W'(i);
        w_alloc_found = 1'b1;
      end
    end
  end

  always_comb begin
    o_sel_valid = 1'b0;
    o_sel_idx   = '0;
    for (int unsigned k = 0; k < NUM_PENDING; k++) begin
      if (!o_sel_valid && r_entries[r_rr + PEND_IDX_W'(k)].valid) begin
        o_sel_valid = 1'b1;
        o_sel_idx   = r_rr + PEND_IDX_W'(k);
      end
    end
    o_sel_entry = r_entries[o_sel_idx];
  end

  always_comb begin
    o_count = '0;
    for (int unsigned i = 0; i < NUM_PENDING; i++) begin
      o_count = o_count + (PEND_IDX_W+1)'(r_entries[i].valid);
    end
  end

  // Alloc target is chosen from registered valid bits, so it never collides
  // with the entry being freed on the same edge.
  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      for (int unsigned i = 0; i < NUM_PENDING; i++) begin
        r_entries[i] <= '0;
      end
      r_rr <= '0;
    end else begin
      if (i_free) begin
        r_entries[i_free_idx].valid <= 1'b0;
        r_rr <= i_free_idx + PEND_IDX_W'(1);
      end else if (i_advance) begin
        r_rr <= r_rr + PEND_IDX_W'(1);
      end
      if (i_alloc && w_alloc_found) begin
        r_entries[w_alloc_idx] <= i_alloc_entry;
      end
    end
  end

endmodule

// File: rtl/mem_fu_nb.sv
// Non-blocking memory unit: address generation, same-cycle store forwarding,
// dcache probe arbitration between new and pending loads, registered CDB slot.
module mem_fu_nb
  import mem_fu_nb_pkg::*;
#(
  parameter int unsigned NUM_PENDING = 4,
  parameter int unsigned TAG_W       = 6,
  parameter int unsigned SQ_IDX_W    = 3,
  parameter int unsigned PEND_IDX_W  = $clog2(NUM_PENDING)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  squash,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            func,
  input  logic [31:0]           rs1,
  input  logic [31:0]           rs2,
  input  logic [31:0]           imm,
  input  logic [TAG_W-1:0]      dest_tag,
  input  logic [SQ_IDX_W-1:0]   sq_idx,
  output logic                  dc_req_valid,
  output logic [31:0]           dc_req_addr,
  input  logic                  dc_hit,
  input  logic [63:0]           dc_hit_data,
  output logic                  sq_wr_valid,
  output logic [SQ_IDX_W-1:0]   sq_wr_idx,
  output logic [31:0]           sq_wr_addr,
  output logic [31:0]           sq_wr_data,
  output logic [7:0]            sq_wr_mask,
  output logic                  cdb_valid,
  output logic [TAG_W-1:0]      cdb_tag,
  output logic [31:0]           cdb_data,
  input  logic                  cdb_grant,
  output logic [PEND_IDX_W:0]   pend_count
);

  logic [31:0]           w_addr;
  mem_func_e             w_func;
  logic                  w_is_store;
  logic                  w_accept;
  logic                  w_st_acc;
  logic                  w_ld_acc;
  logic                  w_slot_free;
  logic                  w_probe_new;
  logic                  w_probe_pend;
  logic                  w_hit;
  logic [31:0]           w_pr_addr;
  mem_func_e             w_pr_func;
  logic [TAG_W-1:0]      w_pr_tag;
  logic                  w_alloc;
  logic                  w_free;
  logic                  w_advance;
  mem_pend_entry_t       w_alloc_entry;
  logic                  w_sel_valid;
  logic [PEND_IDX_W-1:0] w_sel_idx;
  mem_pend_entry_t       w_sel_entry;
  logic                  w_unused;

  logic                  r_cdb_valid;
  logic [TAG_W-1:0]      r_cdb_tag;
  logic [31:0]           r_cdb_data;

  assign in_ready = pend_count < (PEND_IDX_W+1)'(NUM_PENDING);
  assign w_unused = ^{w_sel_entry.valid, w_sel_entry.tag[MAX_TAG_W-1:TAG_W]};

  always_comb begin
    w_addr      = rs1 + imm;
    w_func      = mem_func_e'(func);
    w_is_store  = func_is_store(w_func);
    w_accept    = in_valid && in_ready && !squash;
    w_st_acc    = w_accept && w_is_store;
    w_ld_acc    = w_accept && !w_is_store;
    w_slot_free = !r_cdb_valid || cdb_grant;

    // A new load beats pending retries for the single probe port.
    w_probe_new  = w_ld_acc && w_slot_free;
    w_probe_pend = !w_probe_new && !squash && w_slot_free && w_sel_valid;

    if (w_probe_new) begin
      w_pr_addr = w_addr;
      w_pr_func = w_func;
      w_pr_tag  = dest_tag;
    end else begin
      w_pr_addr = w_sel_entry.addr;
      w_pr_func = w_sel_entry.func;
      w_pr_tag  = w_sel_entry.tag[TAG_W-1:0];
    end

    dc_req_valid = w_probe_new || w_probe_pend;
    dc_req_addr  = dc_req_valid ? {w_pr_addr[31:3], 3'b000} : '0;
    w_hit        = dc_req_valid && dc_hit;

    w_alloc   = w_ld_acc && !(w_probe_new && dc_hit);
    w_free    = w_probe_pend && dc_hit;
    w_advance = w_probe_pend && !dc_hit;

    w_alloc_entry       = '0;
    w_alloc_entry.valid = 1'b1;
    w_alloc_entry.tag   = MAX_TAG_W'(dest_tag);
    w_alloc_entry.addr  = w_addr;
    w_alloc_entry.func  = w_func;

    sq_wr_valid = w_st_acc;
    sq_wr_idx   = w_st_acc ? sq_idx : '0;
    sq_wr_addr  = w_st_acc ? w_addr : '0;
    sq_wr_data  = w_st_acc ? rs2    : '0;
    sq_wr_mask  = w_st_acc ? byte_mask(w_func, w_addr[2:0]) : '0;
  end

  mem_pend_buf #(
    .NUM_PENDING (NUM_PENDING),
    .PEND_IDX_W  (PEND_IDX_W)
  ) u_pend_buf (
    .clock         (clock),
    .reset         (reset),
    .i_clear       (squash),
    .i_alloc       (w_alloc),
    .i_alloc_entry (w_alloc_entry),
    .i_free        (w_free),
    .i_free_idx    (w_sel_idx),
    .i_advance     (w_advance),
    .o_sel_valid   (w_sel_valid),
    .o_sel_idx     (w_sel_idx),
    .o_sel_entry   (w_sel_entry),
    .o_count       (pend_count)
  );

  // A new hit overwrites the slot even while it is being granted, so
  // back-to-back results leave no empty cycle.
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
    end else if (w_hit) begin
      r_cdb_valid <= 1'b1;
      r_cdb_tag   <= w_pr_tag;
      r_cdb_data  <= load_extract(w_pr_func, dc_hit_data, w_pr_addr[2:0]);
    end else if (cdb_grant) begin
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
    end
  end

  assign cdb_valid = r_cdb_valid;
  assign cdb_tag   = r_cdb_tag;
  assign cdb_data  = r_cdb_data;

endmodule
